// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: circular FIFO of {pc, instr} with show-ahead head
// decode into RV32I fields. Flush drops all entries for redirects.
module instr_fetch_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_instr,
   input  logic [ADDR_W-1:0]        in_pc,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        instr31_0,
   output logic [6:0]               opcode,
   output logic [4:0]               rd,
   output logic [2:0]               funct3,
   output logic [4:0]               rs1,
   output logic [4:0]               rs2,
   output logic [6:0]               funct7,
   output logic [ADDR_W-1:0]        pc,
   output logic                     illegal,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] instr_mem_q [DEPTH];
   logic [ADDR_W-1:0] pc_mem_q    [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              push;
   logic              pop;
   logic [DATA_W-1:0] head_instr;

   assign in_ready  = (count_q != CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is left uncleared; head outputs are gated by out_valid instead.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= in_instr;
         pc_mem_q[wr_ptr_q]    <= in_pc;
      end
   end

   assign head_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
   assign pc         = out_valid ? pc_mem_q[rd_ptr_q] : '0;
   assign instr31_0  = head_instr;
   assign opcode     = head_instr[6:0];
   assign rd         = head_instr[11:7];
   assign funct3     = head_instr[14:12];
   assign rs1        = head_instr[19:15];
   assign rs2        = head_instr[24:20];
   assign funct7     = head_instr[31:25];
   assign illegal    = out_valid && (head_instr[1:0] != 2'b11);
   assign count      = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a {pc, instr} scoreboard queue
// checked at every negedge against the DUT head outputs.
module tb_instr_fetch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] instr31_0;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  funct7;
   logic [31:0] pc;
   logic        illegal;
   logic [2:0]  count;

   int checks = 0;
   int failures = 0;
   logic [63:0] sb [$];

   instr_fetch_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .instr31_0(instr31_0), .opcode(opcode), .rd(rd),
      .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
      .pc(pc), .illegal(illegal), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] fields_of(input logic [31:0] w);
      logic [63:0] f;
      f = '0;
      f[32:0] = {w[6:0], w[11:7], w[14:12], w[19:15], w[24:20],
                 w[31:25], (w[1:0] != 2'b11)};
      return f;
   endfunction

   // Apply inputs, check head against scoreboard at negedge, update model.
   task automatic cycle(input logic v, input logic [31:0] ins,
                        input logic [31:0] p, input logic rdy,
                        input logic fl);
      logic [63:0] hd;
      logic        do_pop, do_push;
      in_valid  = v;
      in_instr  = ins;
      in_pc     = p;
      out_ready = rdy;
      flush     = fl;
      @(negedge clk);
      chk("count", 64'(count), 64'(sb.size()));
      chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(sb.size() < 4));
      if (sb.size() != 0) begin
         hd = sb[0];
         chk("head_instr", 64'(instr31_0), 64'(hd[31:0]));
         chk("head_pc", 64'(pc), 64'(hd[63:32]));
         chk("head_fields",
             fields_of(instr31_0) & 64'h0 |
             {31'b0, opcode, rd, funct3, rs1, rs2, funct7, illegal},
             fields_of(hd[31:0]));
      end else begin
         chk("empty_instr", 64'(instr31_0), 64'h0);
         chk("empty_pc", 64'(pc), 64'h0);
         chk("empty_fields",
             {31'b0, opcode, rd, funct3, rs1, rs2, funct7, illegal}, 64'h0);
      end
      do_pop  = (sb.size() != 0) && rdy && !fl;
      do_push = v && (sb.size() < 4) && !fl;
      if (fl) sb.delete();
      else begin
         if (do_pop) void'(sb.pop_front());
         if (do_push) sb.push_back({p, ins});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      chk("rst_count", 64'(count), 64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_in_ready", 64'(in_ready), 64'h1);
      chk("rst_head", 64'(instr31_0), 64'h0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Single push, field decode
      cycle(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("r21_valid", 64'(out_valid), 64'h1);
      chk("r21_opcode", 64'(opcode), 64'h13);
      chk("r21_rd", 64'(rd), 64'h1);
      chk("r21_rs1", 64'(rs1), 64'h0);
      chk("r21_funct3", 64'(funct3), 64'h0);
      chk("r21_pc", 64'(pc), 64'h0);
      chk("r21_illegal", 64'(illegal), 64'h0);
      chk("r21_count", 64'(count), 64'h1);
      @(posedge clk);
      #1;
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Fill to full, fifth push rejected, drain in order
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 32'h1000_0013 + 32'(i) * 32'h80, 32'h40 + 32'(i) * 4,
               1'b0, 1'b0);
      cycle(1'b1, 32'hDEAD_BEEF, 32'h50, 1'b0, 1'b0);
      chk("r22_full_count", 64'(count), 64'h4);
      chk("r22_full_ready", 64'(in_ready), 64'h0);
      for (int i = 0; i < 4; i++)
         cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Streaming with two entries across pointer wrap
      cycle(1'b1, 32'h0011_0113, 32'h100, 1'b0, 1'b0);
      cycle(1'b1, 32'h0022_0233, 32'h104, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++)
         cycle(1'b1, 32'h0300_0003 + (32'(i) << 7), 32'h108 + 32'(i) * 4,
               1'b1, 1'b0);
      chk("r23_count", 64'(count), 64'h2);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Flush overrides same-cycle push and pop
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 32'h0000_0017 + (32'(i) << 15), 32'h200 + 32'(i) * 4,
               1'b0, 1'b0);
      cycle(1'b1, 32'h1234_5677, 32'h300, 1'b1, 1'b1);
      chk("r24_count", 64'(count), 64'h0);
      chk("r24_valid", 64'(out_valid), 64'h0);
      chk("r24_pc", 64'(pc), 64'h0);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Illegal / all-ones decode
      cycle(1'b1, 32'h0000_0000, 32'h400, 1'b0, 1'b0);
      chk("r25_illegal0", 64'(illegal), 64'h1);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle(1'b1, 32'hFFFF_FFFF, 32'h404, 1'b0, 1'b0);
      chk("r25_funct7", 64'(funct7), 64'h7F);
      chk("r25_rs2", 64'(rs2), 64'd31);
      chk("r25_illegal1", 64'(illegal), 64'h0);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Asynchronous reset mid-operation
      cycle(1'b1, 32'h0AAA_0013, 32'h500, 1'b0, 1'b0);
      cycle(1'b1, 32'h0BBB_0013, 32'h504, 1'b0, 1'b0);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("r26_count", 64'(count), 64'h0);
      chk("r26_valid", 64'(out_valid), 64'h0);
      chk("r26_ready", 64'(in_ready), 64'h1);
      chk("r26_head", 64'(instr31_0), 64'h0);
      chk("r26_illegal", 64'(illegal), 64'h0);
      #1;
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      cycle(1'b1, 32'h00A0_0113, 32'h600, 1'b0, 1'b0);
      chk("r26_first", 64'(instr31_0), 64'h00A0_0113);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of queue entries; power of two, minimum 2.
REQ-002 Parameter DATA_W, default 32: instruction width; fixed at 32 for RV32I field slicing.
REQ-003 Parameter ADDR_W, default 32: width of the PC tag stored with each instruction.
REQ-004 Ports SHALL be:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  memory word present on in_instr/in_pc
- in_ready  out  1  queue can accept a word this cycle
- in_instr  in  DATA_W  fetched instruction word
- in_pc  in  ADDR_W  address of in_instr
- flush  in  1  synchronous discard of all entries (branch/jump redirect)
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head entry this cycle
- instr31_0  out  DATA_W  head instruction word
- opcode  out  7  head instr[6:0]
- rd  out  5  head instr[11:7]
- funct3  out  3  head instr[14:12]
- rs1  out  5  head instr[19:15]
- rs2  out  5  head instr[24:20]
- funct7  out  7  head instr[31:25]
- pc  out  ADDR_W  PC tag of head entry
- illegal  out  1  head opcode[1:0] != 2'b11
- count  out  $clog2(DEPTH)+1  current occupancy

Function
REQ-005 Block SHALL be a circular FIFO of DEPTH entries, each holding {in_pc, in_instr}.
REQ-006 Push SHALL occur on a rising clk edge when in_valid && in_ready && !flush.
REQ-007 Pop SHALL occur on a rising clk edge when out_valid && out_ready && !flush.
REQ-008 in_ready SHALL be 1 iff count < DEPTH; no combinational path from out_ready to in_ready.
REQ-009 out_valid SHALL be 1 iff count != 0.
REQ-010 Head outputs (instr31_0, field slices, pc, illegal) SHALL reflect the head entry combinationally from storage (show-ahead); all SHALL be 0 when out_valid = 0.
REQ-011 Latency: a word pushed at edge N SHALL appear on outputs after edge N when the queue was empty at edge N.
REQ-012 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-013 Pointers SHALL wrap modulo DEPTH; order of pops SHALL equal order of pushes across wrap.
REQ-014 Push when full is not accepted; in_valid with in_ready = 0 SHALL leave contents unchanged.
REQ-015 Pop when empty is ignored; out_ready with out_valid = 0 SHALL leave state unchanged.
REQ-016 flush SHALL, on the next edge, set count and both pointers to 0, overriding any same-cycle push or pop.
REQ-017 count SHALL equal pushes minus pops since the last reset/flush and never exceed DEPTH.
REQ-018 Storage contents need not be cleared by flush; outputs SHALL still read 0 per REQ-010.

Reset
REQ-019 rst low SHALL immediately, without clk, force count = 0, pointers = 0, out_valid = 0, in_ready = 1, all head outputs = 0.
REQ-020 Reset asserted mid-operation SHALL discard all entries; the first push after rst release SHALL be the first word popped.

Verification
REQ-021 Reset then push 0x00500093 at pc 0x0 -> next cycle out_valid = 1, opcode = 0x13, rd = 1, rs1 = 0, funct3 = 0, pc = 0x0, illegal = 0, count = 1.
REQ-022 DEPTH = 4, push 4 words with out_ready = 0 -> count = 4, in_ready = 0; fifth push ignored; pops return words 1-4 in order.
REQ-023 Continuous push and pop for 10 cycles with queue holding 2 entries -> count stays 2, outputs in push order across pointer wrap.
REQ-024 Queue holding 3 entries, flush with in_valid = 1 and out_ready = 1 in the same cycle -> next cycle count = 0, out_valid = 0, all head outputs = 0.
REQ-025 Push 0x00000000 -> illegal = 1; push 0xFFFFFFFF -> funct7 = 0x7F, rs2 = 31, illegal = 0.
REQ-026 Queue holding 2 entries, rst pulsed low between clk edges -> outputs clear asynchronously; subsequent push of 0x00A00113 is the first word popped.
